edc_delay_fifo: RTL and testbench
=================================

EDC_DELAY_FIFO -- requirements
Module: edc_delay_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the data word width in bits.
REQ-002 SHALL have parameter STAGES, default 17, meaning the buffer depth and release threshold in words.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning the reset; synchronous and active-high.
REQ-005 SHALL have port d_in, input, WIDTH bits, meaning the write data.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning the writer offers d_in.
REQ-007 SHALL have port in_ready, output, 1 bit, meaning the block accepts d_in this cycle.
REQ-008 SHALL have port flush, input, 1 bit, meaning a single-cycle request to release all stored words.
REQ-009 SHALL have port d_out, output, WIDTH bits, meaning the read data.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning d_out holds a releasable word.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning the reader consumes d_out.
REQ-012 SHALL have port count, output, $clog2(STAGES+1) bits, meaning the number of stored words.

Function
REQ-013 SHALL store words in a STAGES-entry circular buffer with wr_ptr and rd_ptr, each wrapping from STAGES-1 to 0.
REQ-014 SHALL perform a push when in_valid && in_ready and a pop when out_valid && out_ready.
REQ-015 SHALL update count +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-016 SHALL drive d_out = mem[rd_ptr] combinationally from registered state; words leave in write order.
REQ-017 SHALL implement state machine FILL -> STEADY when count reaches STAGES.
REQ-018 SHALL implement state machine STEADY -> DRAIN on flush.
REQ-019 SHALL implement state machine FILL -> DRAIN on flush with count > 0.
REQ-020 SHALL implement state machine DRAIN -> FILL when the last word pops.
REQ-021 SHALL ignore flush when count == 0.
REQ-022 SHALL drive out_valid = (state == STEADY) || (state == DRAIN && count != 0); in FILL, out_valid = 0.
REQ-023 SHALL, in STEADY, keep a word in the buffer until STAGES newer-or-equal words are present, giving an accepted-word-to-release latency of STAGES pushes.
REQ-024 SHALL drive in_ready = (count < STAGES) || (out_valid && out_ready) in FILL and STEADY.
REQ-025 SHALL drive in_ready = 0 in DRAIN.
REQ-026 SHALL, when full in STEADY with in_valid and out_ready, push and pop in the same cycle, with count held at STAGES.
REQ-027 SHALL, when full in STEADY with out_ready = 0, hold in_ready = 0 and keep all stored data.
REQ-028 SHALL treat flush arriving in the same cycle as a push as follows: the push completes first, then the transition to DRAIN.

Reset
REQ-029 SHALL, on rst = 1 at a clk edge, clear wr_ptr, rd_ptr and count to 0, set state to FILL, and drive out_valid = 0 and in_ready = 1 the next cycle.
REQ-030 SHALL give rst priority over push, pop and flush, including mid-DRAIN; the memory contents are not cleared.

Configuration
REQ-031 SHALL, with EDC_DELAY_PARITY_EN defined, store one even-parity bit per word computed on push.
REQ-032 SHALL, with EDC_DELAY_PARITY_EN defined, add output par_err (1 bit) asserted combinationally with out_valid when the stored parity mismatches mem[rd_ptr].
REQ-033 SHALL, with EDC_DELAY_PARITY_EN defined, add output par_err_sticky, set on any popped mismatch and cleared only by rst.
REQ-034 SHALL, without EDC_DELAY_PARITY_EN, have no parity storage and no par_err or par_err_sticky ports.

Structure
REQ-035 SHALL place the WIDTH and STAGES defaults and the state enum (FILL, STEADY, DRAIN) in shared package edc_pkg.
REQ-036 SHALL instantiate one sub-module, edc_regfile: STAGES x (WIDTH[+1]) register array with one synchronous write port and one asynchronous read port, no reset.

Verification
REQ-037 SHALL cover: 17 pushes of 0x0001..0x0011 with out_ready = 1 -> out_valid rises after the 17th push, d_out = 0x0001, count = 17.
REQ-038 SHALL cover: continuous push and pop in STEADY with 0x0012.. -> d_out sequence 0x0001, 0x0002, ... with count constant at 17.
REQ-039 SHALL cover: full with out_ready = 0 for 5 cycles and in_valid = 1 -> in_ready = 0 and d_out stable at its value.
REQ-040 SHALL cover: 5 pushes then flush -> 5 words pop in order, in_ready = 0 during DRAIN, then FILL with count = 0.
REQ-041 SHALL cover: rst asserted mid-DRAIN with 3 words left -> next cycle count = 0, out_valid = 0, in_ready = 1.
REQ-042 SHALL cover, with EDC_DELAY_PARITY_EN: force one stored bit flipped -> par_err = 1 on that word only, and par_err_sticky remains 1 until rst.

Source files
------------

// File: rtl/edc_pkg.sv
// rtl/edc_pkg.sv - shared defaults and state encoding for the edc delay fifo
package edc_pkg;

    localparam int EDC_WIDTH  = 16;
    localparam int EDC_STAGES = 17;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STEADY = 2'd1,
        DRAIN  = 2'd2
    } edc_state_t;

endpackage

// File: rtl/edc_regfile.sv
// rtl/edc_regfile.sv - unreset register array, one sync write port, one async read port
module edc_regfile #(
    parameter int DW    = 16,
    parameter int DEPTH = 17,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/edc_delay_fifo.sv
// rtl/edc_delay_fifo.sv - fixed-latency delay fifo with flush drain
// optional per-word even parity when EDC_DELAY_PARITY_EN is defined
module edc_delay_fifo
    import edc_pkg::*;
#(
    parameter int WIDTH  = EDC_WIDTH,
    parameter int STAGES = EDC_STAGES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             d_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [WIDTH-1:0]             d_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(STAGES+1)-1:0]  count
`ifdef EDC_DELAY_PARITY_EN
    ,
    output logic                         par_err,
    output logic                         par_err_sticky
`endif
);

    localparam int CW = $clog2(STAGES + 1);
    localparam int PW = (STAGES > 1) ? $clog2(STAGES) : 1;
`ifdef EDC_DELAY_PARITY_EN
    localparam int DW = WIDTH + 1;
`else
    localparam int DW = WIDTH;
`endif

    edc_state_t    state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;
    logic [DW-1:0] wr_word;
    logic [DW-1:0] rd_word;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(STAGES - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_valid = (state == STEADY) || ((state == DRAIN) && (count != '0));
    assign in_ready  = (state != DRAIN) &&
                       ((count < CW'(STAGES)) || (out_valid && out_ready));
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

`ifdef EDC_DELAY_PARITY_EN
    assign wr_word = {^d_in, d_in};
    assign d_out   = rd_word[WIDTH-1:0];
    assign par_err = out_valid && ((^rd_word[WIDTH-1:0]) != rd_word[WIDTH]);
`else
    assign wr_word = d_in;
    assign d_out   = rd_word;
`endif

    // Flush is evaluated against the post-push count so a word accepted in the
    // flush cycle is drained along with the rest.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= FILL;
`ifdef EDC_DELAY_PARITY_EN
            par_err_sticky <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_nxt;
`ifdef EDC_DELAY_PARITY_EN
            if (pop && par_err) begin
                par_err_sticky <= 1'b1;
            end
`endif
            case (state)
                FILL: begin
                    if (flush && (count_nxt != '0)) begin
                        state <= DRAIN;
                    end else if (count_nxt == CW'(STAGES)) begin
                        state <= STEADY;
                    end
                end
                STEADY: begin
                    if (flush && (count_nxt != '0)) begin
                        state <= DRAIN;
                    end else if (count_nxt != CW'(STAGES)) begin
                        state <= FILL;
                    end
                end
                DRAIN: begin
                    if (pop && (count == CW'(1))) begin
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    edc_regfile #(
        .DW    (DW),
        .DEPTH (STAGES),
        .AW    (PW)
    ) u_rf (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_word),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

endmodule

// File: tb/tb_edc_delay_fifo.sv
// tb/tb_edc_delay_fifo.sv - scoreboard bench for edc_delay_fifo
module tb_edc_delay_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [15:0] d_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  count;
`ifdef EDC_DELAY_PARITY_EN
    logic        par_err;
    logic        par_err_sticky;
`endif

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_w;

    always #5 clk = ~clk;

    edc_delay_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .d_out     (d_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
`ifdef EDC_DELAY_PARITY_EN
        ,
        .par_err        (par_err),
        .par_err_sticky (par_err_sticky)
`endif
    );

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_order: got %h, scoreboard empty", d_out);
            end else begin
                exp_w = exp_q.pop_front();
                if (d_out !== exp_w) begin
                    bad++;
                    $display("FAIL pop_order: got %h, expected %h", d_out, exp_w);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic f,
                        input logic ordy, input logic accepted);
        in_valid  = v;
        d_in      = d;
        flush     = f;
        out_ready = ordy;
        if (accepted) exp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_count", 16'(count), 16'd0);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // fill: 17 pushes, release begins only after the 17th
        for (int i = 1; i <= 17; i++) begin
            if (i == 17) begin
                chk("fill16_out_valid", 16'(out_valid), 16'd0);
                chk("fill16_count", 16'(count), 16'd16);
            end
            step(1'b1, 16'(i), 1'b0, 1'b1, 1'b1);
        end
        chk("fill_out_valid", 16'(out_valid), 16'd1);
        chk("fill_d_out", d_out, 16'h0001);
        chk("fill_count", 16'(count), 16'd17);
        chk("fill_in_ready", 16'(in_ready), 16'd1);

        // steady: simultaneous push/pop, count pinned at 17
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'h0012 + 16'(i), 1'b0, 1'b1, 1'b1);
            chk("steady_count", 16'(count), 16'd17);
        end
        chk("steady_d_out", d_out, 16'h000B);

        // full with reader stalled: nothing accepted, head stable
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
            chk("stall_in_ready", 16'(in_ready), 16'd0);
            chk("stall_d_out", d_out, 16'h000B);
            chk("stall_count", 16'(count), 16'd17);
        end

        // 5 pushes then flush from FILL
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b1, 1'b1);
        chk("pre_flush_out_valid", 16'(out_valid), 16'd0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("drain_out_valid", 16'(out_valid), 16'd1);
        chk("drain_count", 16'(count), 16'd5);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            d_in     = 16'hDEAD;
            #1;
            chk("drain_in_ready", 16'(in_ready), 16'd0);
            step(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0);
        end
        in_valid = 1'b0;
        #1;
        chk("post_drain_count", 16'(count), 16'd0);
        chk("post_drain_out_valid", 16'(out_valid), 16'd0);
        chk("post_drain_in_ready", 16'(in_ready), 16'd1);
        chk("post_drain_sb_empty", 16'(exp_q.size()), 16'd0);

        // reset mid-drain with 3 words left
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b0;
        chk("mid_drain_count", 16'(count), 16'd3);
        do_reset();

        // flush in the same cycle as a push: push lands, then drain
        for (int i = 1; i <= 2; i++) step(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h0303, 1'b1, 1'b0, 1'b1);
        chk("flush_push_count", 16'(count), 16'd3);
        chk("flush_push_out_valid", 16'(out_valid), 16'd1);
        chk("flush_push_in_ready", 16'(in_ready), 16'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        chk("flush_push_end_count", 16'(count), 16'd0);
        chk("flush_push_sb_empty", 16'(exp_q.size()), 16'd0);

        // flush while empty is ignored
        step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        chk("empty_flush_out_valid", 16'(out_valid), 16'd0);
        chk("empty_flush_in_ready", 16'(in_ready), 16'd1);
        step(1'b1, 16'h0401, 1'b0, 1'b1, 1'b1);
        chk("empty_flush_then_push_count", 16'(count), 16'd1);
        chk("empty_flush_then_push_valid", 16'(out_valid), 16'd0);

`ifdef EDC_DELAY_PARITY_EN
        do_reset();
        for (int i = 1; i <= 17; i++) step(1'b1, 16'h0020 + 16'(i), 1'b0, 1'b0, 1'b1);
        chk("par_clean", 16'(par_err), 16'd0);
        begin
            logic [16:0] tmp;
            tmp = dut.u_rf.mem[0];
            tmp[16] = ~tmp[16];
            dut.u_rf.mem[0] = tmp;
        end
        #1;
        chk("par_err_flipped", 16'(par_err), 16'd1);
        step(1'b1, 16'h0040, 1'b0, 1'b1, 1'b1);
        chk("par_err_next", 16'(par_err), 16'd0);
        chk("par_sticky_set", 16'(par_err_sticky), 16'd1);
        step(1'b1, 16'h0041, 1'b0, 1'b1, 1'b1);
        chk("par_sticky_hold", 16'(par_err_sticky), 16'd1);
        do_reset();
        chk("par_sticky_clr", 16'(par_err_sticky), 16'd0);
`endif

        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
